// File: rtl/ser_pkg.sv
// Shared types and constants for the byte serializer and its receive-side register.
package ser_pkg;

    localparam int unsigned SER_WIDTH = 8;

    typedef enum logic {
        IDLE,
        SHIFT
    } ser_state_t;

    // Bit-counter width for a given word width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Bit position counter: clear has priority over increment, terminal at WIDTH-1.
module ser_bit_counter
    import ser_pkg::*;
#(
    parameter int unsigned WIDTH = SER_WIDTH,
    parameter int unsigned CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             terminal_c
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

    assign terminal_c = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/byte_serializer.sv
// Parallel-in/serial-out stage, MSB first, with a one-word hold register for gapless words.
module byte_serializer
    import ser_pkg::*;
#(
    parameter int unsigned WIDTH = SER_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    ser_state_t       state;
    logic [WIDTH-1:0] shifter;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic [CNT_W-1:0] count;
    logic             terminal_c;
    logic             xfer_c;
    logic             pre_last_c;
    logic             cnt_clr_c;
    logic             cnt_inc_c;

    // in_ready depends only on registered hold state, never on in_valid.
    assign in_ready   = ~hold_full;
    assign xfer_c     = in_valid & in_ready;
    // The shifter is zero whenever idle, so the line rests at 0.
    assign ser_out    = shifter[WIDTH-1];
    assign pre_last_c = (count == CNT_W'(WIDTH - 2));
    assign cnt_clr_c  = (state == IDLE) | terminal_c;
    assign cnt_inc_c  = (state == SHIFT);

    ser_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk        (clk),
        .reset      (reset),
        .clr        (cnt_clr_c),
        .inc        (cnt_inc_c),
        .count      (count),
        .terminal_c (terminal_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shifter   <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            ser_valid <= 1'b0;
            ser_first <= 1'b0;
            ser_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer_c) begin
                        state     <= SHIFT;
                        shifter   <= in_data;
                        ser_valid <= 1'b1;
                        ser_first <= 1'b1;
                        ser_last  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (terminal_c) begin
                        // End of word: chain the next word without an idle bit if one is available.
                        ser_first <= 1'b1;
                        ser_last  <= 1'b0;
                        if (hold_full) begin
                            shifter   <= hold;
                            hold      <= '0;
                            hold_full <= 1'b0;
                        end else if (xfer_c) begin
                            shifter <= in_data;
                        end else begin
                            state     <= IDLE;
                            shifter   <= '0;
                            ser_valid <= 1'b0;
                            ser_first <= 1'b0;
                        end
                    end else begin
                        shifter   <= {shifter[WIDTH-2:0], 1'b0};
                        ser_first <= 1'b0;
                        ser_last  <= pre_last_c;
                        if (xfer_c) begin
                            hold      <= in_data;
                            hold_full <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_serializer.sv
// Self-checking bench: random and directed words against a bit-queue model of the serial stream.
module tb_byte_serializer;
    import ser_pkg::*;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         ser_out;
    logic         ser_valid;
    logic         ser_first;
    logic         ser_last;

    logic [3:0]   in_data4;
    logic         in_valid4;
    logic         in_ready4;
    logic         ser_out4;
    logic         ser_valid4;
    logic         ser_first4;
    logic         ser_last4;

    byte_serializer #(.WIDTH(W)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .ser_first (ser_first),
        .ser_last  (ser_last)
    );

    byte_serializer #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data4),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .ser_out   (ser_out4),
        .ser_valid (ser_valid4),
        .ser_first (ser_first4),
        .ser_last  (ser_last4)
    );

    always #5 clk = ~clk;

    // One expected serial bit; the queue holds every accepted bit not yet seen on the line.
    typedef struct {
        bit           b;
        bit           first;
        bit           last;
        int           pos;
        logic [W-1:0] word;
    } bit_t;

    bit_t         q[$];
    int           errors   = 0;
    int           checks   = 0;
    int           last_pos = -1;
    logic [W-1:0] down_reg = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_word(input logic [W-1:0] w);
        bit_t e;
        for (int i = 0; i < int'(W); i++) begin
            e.b     = w[W-1-i];
            e.first = (i == 0);
            e.last  = (i == int'(W) - 1);
            e.pos   = i;
            e.word  = w;
            q.push_back(e);
        end
    endtask

    // Check the current cycle against the model, then drive inputs for the coming edge.
    task automatic cycle(input bit v, input logic [W-1:0] d, output bit acc);
        bit exp_ready;
        @(negedge clk);
        exp_ready = (q.size() <= int'(W));
        check("ser_valid", 32'(ser_valid), 32'(q.size() != 0));
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        if (ser_valid) down_reg = {down_reg[W-2:0], ser_out};
        if (q.size() != 0) begin
            check("ser_out", 32'(ser_out), 32'(q[0].b));
            check("ser_first", 32'(ser_first), 32'(q[0].first));
            check("ser_last", 32'(ser_last), 32'(q[0].last));
            if (q[0].last) check("down_word", 32'(down_reg), 32'(q[0].word));
            last_pos = q[0].pos;
            void'(q.pop_front());
        end else begin
            check("idle_ser_out", 32'(ser_out), 32'd0);
            check("idle_ser_first", 32'(ser_first), 32'd0);
            check("idle_ser_last", 32'(ser_last), 32'd0);
            last_pos = -1;
        end
        in_valid = v;
        in_data  = d;
        acc      = v && exp_ready;
        if (acc) push_word(d);
    endtask

    task automatic send(input logic [W-1:0] d);
        bit acc;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, d, acc);
            if (acc) return;
        end
        check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, acc);
    endtask

    task automatic test_width4();
        logic [7:0] bits  = '0;
        logic [7:0] lasts = '0;
        int         n     = 0;
        for (int c = 0; c < 30 && n < 8; c++) begin
            @(negedge clk);
            if (ser_valid4) begin
                bits  = {bits[6:0], ser_out4};
                lasts = {lasts[6:0], ser_last4};
                n++;
            end
            if (c == 0) begin
                in_valid4 = 1'b1;
                in_data4  = 4'h9;
            end else if (c == 1) begin
                in_data4 = 4'h6;
            end else begin
                in_valid4 = 1'b0;
            end
        end
        check("w4_bit_count", 32'(n), 32'd8);
        check("w4_bits", 32'(bits), 32'h96);
        check("w4_lasts", 32'(lasts), 32'h11);
    endtask

    initial begin
        bit acc;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_valid4 = 1'b0;
        in_data4  = '0;
        #1;
        check("rst_ser_out", 32'(ser_out), 32'd0);
        check("rst_ser_valid", 32'(ser_valid), 32'd0);
        check("rst_ser_first", 32'(ser_first), 32'd0);
        check("rst_ser_last", 32'(ser_last), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        #11 reset = 1'b1;

        test_width4();
        idle(4);

        // Single word A5.
        cycle(1'b1, 8'hA5, acc);
        idle(11);

        // Two words offered back to back.
        send(8'h3C);
        send(8'hC3);
        idle(20);

        // Three words back to back; the third waits for hold to drain.
        send(8'h01);
        send(8'h80);
        send(8'hFF);
        idle(30);

        // Accept on the end-of-word edge with hold empty.
        send(8'h5A);
        for (int i = 0; i < 20 && q.size() != 1; i++) cycle(1'b0, '0, acc);
        cycle(1'b1, 8'hC7, acc);
        idle(12);

        // Asynchronous reset during bit 4 of F0 with a word held.
        send(8'hF0);
        send(8'h5A);
        for (int i = 0; i < 20 && last_pos != 3; i++) cycle(1'b0, '0, acc);
        check("hold_full_before_reset", 32'(in_ready), 32'd0);
        #2 reset = 1'b0;
        #1;
        check("async_ser_out", 32'(ser_out), 32'd0);
        check("async_ser_valid", 32'(ser_valid), 32'd0);
        check("async_ser_first", 32'(ser_first), 32'd0);
        check("async_ser_last", 32'(ser_last), 32'd0);
        check("async_in_ready", 32'(in_ready), 32'd1);
        q.delete();
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        idle(12);

        // Random traffic.
        for (int i = 0; i < 500; i++) cycle($urandom_range(0, 2) != 0, 8'($urandom), acc);
        idle(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
